// File: rtl/stream_pkg.sv
// Shared definitions for the marker-framed stream slave: FSM state encoding
// and the default packet-opening marker word.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_MARKER = 8'hD5;

endpackage

// File: rtl/stream_buffer.sv
// Packet storage: DEPTH x WIDTH register file with one synchronous write port
// and one combinational read port.
module stream_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is deliberately left without reset; the FSM never reads a
    // slot before writing it, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_slave.sv
// Marker-framed packet receiver: waits for MARKER, collects PACK_SIZE words,
// validates framing via s_last, then replays the packet downstream.
module stream_slave
    import stream_pkg::*;
#(
    parameter int                   PACK_SIZE = 8,
    parameter int                   MARK_SIZE = 8,
    parameter logic [MARK_SIZE-1:0] MARKER    = MARK_SIZE'(DEFAULT_MARKER)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    input  logic [MARK_SIZE-1:0] s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [MARK_SIZE-1:0] m_data,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 pack_err,
    output logic [7:0]           pack_cnt
);

    localparam int               IDX_W    = (PACK_SIZE > 1) ? $clog2(PACK_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_SIZE - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] widx, widx_next;
    logic [IDX_W-1:0] ridx, ridx_next;
    logic             err_next;
    logic [7:0]       cnt_next;
    logic             wr_en;
    logic             accept;
    logic             deliver;

    // Handshake outputs decode straight from registered state.
    assign s_ready = (state != ST_DRAIN);
    assign m_valid = (state == ST_DRAIN);
    assign m_last  = (state == ST_DRAIN) && (ridx == LAST_IDX);
    assign accept  = s_valid && s_ready;
    assign deliver = m_valid && m_ready;

    stream_buffer #(
        .DEPTH (PACK_SIZE),
        .WIDTH (MARK_SIZE),
        .IDX_W (IDX_W)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (widx),
        .wr_data (s_data),
        .rd_addr (ridx),
        .rd_data (m_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            widx     <= '0;
            ridx     <= '0;
            pack_err <= 1'b0;
            pack_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            widx     <= widx_next;
            ridx     <= ridx_next;
            pack_err <= err_next;
            pack_cnt <= cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        widx_next  = widx;
        ridx_next  = ridx;
        err_next   = 1'b0;
        cnt_next   = pack_cnt;
        wr_en      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept && (s_data == MARKER)) begin
                    state_next = ST_RECV;
                    widx_next  = '0;
                end
            end
            ST_RECV: begin
                if (accept) begin
                    // Framing is valid only when s_last coincides with the final slot.
                    if (s_last != (widx == LAST_IDX)) begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                        widx_next  = '0;
                    end else begin
                        wr_en = 1'b1;
                        if (widx == LAST_IDX) begin
                            state_next = ST_DRAIN;
                            ridx_next  = '0;
                        end else begin
                            widx_next = widx + IDX_W'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (deliver) begin
                    if (ridx == LAST_IDX) begin
                        state_next = ST_IDLE;
                        ridx_next  = '0;
                        cnt_next   = pack_cnt + 8'd1;
                    end else begin
                        ridx_next = ridx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
